// File: rtl/spmv_nz_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | spmv_nz_feeder: joins each nonzero with x[col] and feeds the mac stage  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module spmv_nz_feeder #(
  parameter int INTERMEDIATOR_DEPTH      = 1024,
  parameter int LOG2_INTERMEDIATOR_DEPTH = 10,
  parameter int VECTOR_DEPTH             = 4096,
  parameter int LOG2_VECTOR_DEPTH        = 12,
  parameter int SKID_DEPTH               = 4,
  parameter int FLUSH_DELAY              = 64
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                vec_wr,
  input  logic [LOG2_VECTOR_DEPTH-1:0]        vec_addr,
  input  logic [63:0]                         vec_data,
  input  logic                                nz_valid,
  output logic                                nz_ready,
  input  logic [31:0]                         nz_row,
  input  logic [LOG2_VECTOR_DEPTH-1:0]        nz_col,
  input  logic [63:0]                         nz_val,
  input  logic                                nz_last,
  output logic                                mac_wr,
  output logic [LOG2_INTERMEDIATOR_DEPTH-1:0] mac_row,
  output logic [63:0]                         mac_v0,
  output logic [63:0]                         mac_v1,
  input  logic                                mac_stall,
  output logic                                mac_eof,
  output logic                                busy,
  output logic                                row_err,
  output logic [31:0]                         nz_count
);

  localparam int c_PTR_W   = $clog2(SKID_DEPTH);
  localparam int c_OCC_W   = c_PTR_W + 2;
  localparam int c_FLUSH_W = (FLUSH_DELAY > 1) ? $clog2(FLUSH_DELAY) : 1;
  localparam logic [c_OCC_W-1:0]   c_SKID       = c_OCC_W'(SKID_DEPTH);
  localparam logic [c_FLUSH_W-1:0] c_FLUSH_LAST = c_FLUSH_W'(FLUSH_DELAY - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_FLUSH  = 2'd2,
    S_EOF    = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [63:0] r_mem [VECTOR_DEPTH];

  logic                                r_s1_valid;
  logic [LOG2_VECTOR_DEPTH-1:0]        r_s1_addr;
  logic [LOG2_INTERMEDIATOR_DEPTH-1:0] r_s1_row;
  logic [63:0]                         r_s1_val;
  logic                                r_s1_last;
  logic                                r_s2_valid;
  logic [LOG2_INTERMEDIATOR_DEPTH-1:0] r_s2_row;
  logic [63:0]                         r_s2_val;
  logic [63:0]                         r_s2_x;
  logic                                r_s2_last;

  logic [LOG2_INTERMEDIATOR_DEPTH-1:0] r_f_row  [SKID_DEPTH];
  logic [63:0]                         r_f_v0   [SKID_DEPTH];
  logic [63:0]                         r_f_v1   [SKID_DEPTH];
  logic                                r_f_last [SKID_DEPTH];
  logic [c_PTR_W:0]                    r_wr_ptr;
  logic [c_PTR_W:0]                    r_rd_ptr;

  logic [c_FLUSH_W-1:0] r_flush_cnt;
  logic [31:0]          r_prev_row;
  logic                 r_row_seen;
  logic                 r_row_err;
  logic                 r_last_seen;
  logic [31:0]          r_nz_count;

  logic [c_PTR_W:0]     w_fifo_count;
  logic                 w_fifo_empty;
  logic [c_OCC_W-1:0]   w_occ;
  logic                 w_nz_ready;
  logic                 w_accept;
  logic                 w_mac_wr;
  logic                 w_head_last;
  logic [c_PTR_W-1:0]   w_wr_idx;
  logic [c_PTR_W-1:0]   w_rd_idx;

  assign w_fifo_count = r_wr_ptr - r_rd_ptr;
  assign w_fifo_empty = (r_wr_ptr == r_rd_ptr);
  assign w_wr_idx     = r_wr_ptr[c_PTR_W-1:0];
  assign w_rd_idx     = r_rd_ptr[c_PTR_W-1:0];

  // Credits cover both queued entries and lookups still in the RAM pipeline.
  assign w_occ = c_OCC_W'(w_fifo_count) + c_OCC_W'(r_s1_valid) + c_OCC_W'(r_s2_valid);

  assign w_nz_ready = rst & ((r_state == S_IDLE) || (r_state == S_STREAM)) &
                      !vec_wr & !r_last_seen & (w_occ < c_SKID);
  assign w_accept   = nz_valid & w_nz_ready;
  assign w_mac_wr   = !w_fifo_empty & !mac_stall;
  assign w_head_last = r_f_last[w_rd_idx];

  assign nz_ready = w_nz_ready;
  assign mac_wr   = w_mac_wr;
  assign mac_row  = w_mac_wr ? r_f_row[w_rd_idx] : '0;
  assign mac_v0   = w_mac_wr ? r_f_v0[w_rd_idx]  : '0;
  assign mac_v1   = w_mac_wr ? r_f_v1[w_rd_idx]  : '0;
  assign mac_eof  = (r_state == S_EOF);
  assign busy     = (r_state != S_IDLE) | r_s1_valid | r_s2_valid | !w_fifo_empty;
  assign row_err  = r_row_err;
  assign nz_count = r_nz_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = S_STREAM;
      S_STREAM: if (w_mac_wr && w_head_last) w_state_nxt = S_FLUSH;
      S_FLUSH:  if (r_flush_cnt == c_FLUSH_LAST) w_state_nxt = S_EOF;
      S_EOF:    w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // x RAM: address register feeds a data register, giving two-cycle reads.
  always_ff @(posedge clk) begin
    if (vec_wr) begin
      r_mem[vec_addr] <= vec_data;
    end
    r_s2_x <= r_mem[r_s1_addr];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_valid <= 1'b0;
      r_s1_addr  <= '0;
      r_s1_row   <= '0;
      r_s1_val   <= '0;
      r_s1_last  <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s2_row   <= '0;
      r_s2_val   <= '0;
      r_s2_last  <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_addr <= nz_col;
        r_s1_row  <= LOG2_INTERMEDIATOR_DEPTH'(nz_row % 32'(INTERMEDIATOR_DEPTH));
        r_s1_val  <= nz_val;
        r_s1_last <= nz_last;
      end
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_row  <= r_s1_row;
        r_s2_val  <= r_s1_val;
        r_s2_last <= r_s1_last;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_s2_valid) begin
      r_f_row[w_wr_idx]  <= r_s2_row;
      r_f_v0[w_wr_idx]   <= r_s2_val;
      r_f_v1[w_wr_idx]   <= r_s2_x;
      r_f_last[w_wr_idx] <= r_s2_last;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (r_s2_valid) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_mac_wr)   r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_flush_cnt <= '0;
    end else if (r_state == S_FLUSH) begin
      r_flush_cnt <= r_flush_cnt + 1'b1;
    end else begin
      r_flush_cnt <= '0;
    end
  end

  // Row ordering is tracked per stream; the error flag itself is sticky.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prev_row  <= '0;
      r_row_seen  <= 1'b0;
      r_row_err   <= 1'b0;
      r_last_seen <= 1'b0;
    end else if (r_state == S_EOF) begin
      r_prev_row  <= '0;
      r_row_seen  <= 1'b0;
      r_last_seen <= 1'b0;
    end else if (w_accept) begin
      r_prev_row <= nz_row;
      r_row_seen <= 1'b1;
      if (r_row_seen && (nz_row < r_prev_row)) r_row_err <= 1'b1;
      if (nz_last) r_last_seen <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_nz_count <= '0;
    end else if (r_state == S_EOF) begin
      r_nz_count <= '0;
    end else if (w_mac_wr && (r_nz_count != 32'hFFFF_FFFF)) begin
      r_nz_count <= r_nz_count + 32'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spmv_nz_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_spmv_nz_feeder: directed self-checking bench for spmv_nz_feeder      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_spmv_nz_feeder;

  localparam logic [63:0] D05 = 64'h3FE0_0000_0000_0000;
  localparam logic [63:0] D10 = 64'h3FF0_0000_0000_0000;
  localparam logic [63:0] D15 = 64'h3FF8_0000_0000_0000;
  localparam logic [63:0] D20 = 64'h4000_0000_0000_0000;
  localparam logic [63:0] D30 = 64'h4008_0000_0000_0000;
  localparam logic [63:0] D40 = 64'h4010_0000_0000_0000;
  localparam logic [63:0] D80 = 64'h4020_0000_0000_0000;
  localparam logic [63:0] DM1 = 64'hBFF0_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        vec_wr;
  logic [11:0] vec_addr;
  logic [63:0] vec_data;
  logic        nz_valid;
  logic        nz_ready;
  logic [31:0] nz_row;
  logic [11:0] nz_col;
  logic [63:0] nz_val;
  logic        nz_last;
  logic        mac_wr;
  logic [9:0]  mac_row;
  logic [63:0] mac_v0;
  logic [63:0] mac_v1;
  logic        mac_stall;
  logic        mac_eof;
  logic        busy;
  logic        row_err;
  logic [31:0] nz_count;

  spmv_nz_feeder dut (
    .clk(clk), .rst(rst),
    .vec_wr(vec_wr), .vec_addr(vec_addr), .vec_data(vec_data),
    .nz_valid(nz_valid), .nz_ready(nz_ready), .nz_row(nz_row), .nz_col(nz_col),
    .nz_val(nz_val), .nz_last(nz_last),
    .mac_wr(mac_wr), .mac_row(mac_row), .mac_v0(mac_v0), .mac_v1(mac_v1),
    .mac_stall(mac_stall), .mac_eof(mac_eof),
    .busy(busy), .row_err(row_err), .nz_count(nz_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          q_cyc [$];
  logic [9:0]  q_row [$];
  logic [63:0] q_v0  [$];
  logic [63:0] q_v1  [$];
  int          eof_cnt = 0;
  int          eof_cyc = 0;
  logic [31:0] eof_nzc = '0;

  // Push/eof monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (mac_wr) begin
      q_cyc.push_back(cyc);
      q_row.push_back(mac_row);
      q_v0.push_back(mac_v0);
      q_v1.push_back(mac_v1);
    end
    if (mac_eof) begin
      eof_cnt = eof_cnt + 1;
      eof_cyc = cyc;
      eof_nzc = nz_count;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    q_cyc.delete();
    q_row.delete();
    q_v0.delete();
    q_v1.delete();
  endtask

  task automatic vec_write(input logic [11:0] a, input logic [63:0] d);
    vec_wr   = 1'b1;
    vec_addr = a;
    vec_data = d;
    tick();
    vec_wr   = 1'b0;
  endtask

  task automatic send(input logic [31:0] r, input logic [11:0] c, input logic [63:0] v,
                      input logic l, output int acc);
    nz_valid = 1'b1;
    nz_row   = r;
    nz_col   = c;
    nz_val   = v;
    nz_last  = l;
    acc      = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (nz_ready) begin
        acc = cyc;
        break;
      end
      tick();
    end
    if (acc < 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL send_timeout: observed no accept expected accept within 200 cycles");
    end
    tick();
  endtask

  task automatic wait_eof(input int target, input string tag);
    for (int k = 0; k < 400; k++) begin
      if (eof_cnt >= target) break;
      tick();
    end
    chk(tag, 64'(eof_cnt), 64'(target));
  endtask

  logic [63:0] xv [4];
  logic [63:0] exp_v1 [$];
  int acc0;
  int acc_tmp;
  int ai;
  int stall_wr;
  logic last_ready;

  initial begin
    rst = 1'b0; vec_wr = 1'b0; vec_addr = '0; vec_data = '0;
    nz_valid = 1'b0; nz_row = '0; nz_col = '0; nz_val = '0; nz_last = 1'b0;
    mac_stall = 1'b0;
    xv[0] = D10; xv[1] = D20; xv[2] = D30; xv[3] = D40;
    tick(); tick();
    chk("rst_nz_ready", 64'(nz_ready), 64'(1'b0));
    chk("rst_mac_wr",   64'(mac_wr),   64'(1'b0));
    chk("rst_mac_eof",  64'(mac_eof),  64'(1'b0));
    chk("rst_busy",     64'(busy),     64'(1'b0));
    chk("rst_row_err",  64'(row_err),  64'(1'b0));
    chk("rst_nz_count", 64'(nz_count), 64'd0);
    rst = 1'b1;
    tick();

    // Basic stream
    for (int i = 0; i < 4; i++) vec_write(12'(i), xv[i]);
    clear_q();
    send(32'd0, 12'd0, D20, 1'b0, acc0);
    send(32'd0, 12'd3, D15, 1'b0, acc_tmp);
    send(32'd1, 12'd2, DM1, 1'b0, acc_tmp);
    send(32'd2, 12'd1, D05, 1'b1, acc_tmp);
    nz_valid = 1'b0; nz_last = 1'b0;
    wait_eof(1, "t1_eof");
    chk("t1_push_count", 64'(q_v1.size()), 64'd4);
    if (q_v1.size() == 4) begin
      chk("t1_v1_0", q_v1[0], D10);
      chk("t1_v1_1", q_v1[1], D40);
      chk("t1_v1_2", q_v1[2], D30);
      chk("t1_v1_3", q_v1[3], D20);
      chk("t1_v0_2", q_v0[2], DM1);
      chk("t1_row_3", 64'(q_row[3]), 64'd2);
      chk("t1_latency", 64'(q_cyc[0] - acc0), 64'd3);
      chk("t1_eof_delay", 64'(eof_cyc - q_cyc[3]), 64'd65);
    end
    chk("t1_nz_count_at_eof", 64'(eof_nzc), 64'd4);
    tick();
    chk("t1_nz_count_after", 64'(nz_count), 64'd0);
    chk("t1_busy_after", 64'(busy), 64'(1'b0));
    chk("t1_single_eof", 64'(eof_cnt), 64'd1);

    // Stall while streaming 16 nonzeros
    clear_q();
    mac_stall = 1'b1;
    ai = 0;
    stall_wr = 0;
    last_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      nz_valid = 1'b1;
      nz_row = 32'(ai); nz_col = 12'(ai % 4); nz_val = 64'h100 + 64'(ai); nz_last = 1'b0;
      @(negedge clk);
      if (mac_wr) stall_wr++;
      last_ready = nz_ready;
      if (nz_ready) ai++;
      tick();
    end
    chk("t2_accepted_in_stall", 64'(ai), 64'd4);
    chk("t2_wr_in_stall", 64'(stall_wr), 64'd0);
    chk("t2_ready_in_stall", 64'(last_ready), 64'(1'b0));
    chk("t2_busy_in_stall", 64'(busy), 64'(1'b1));
    mac_stall = 1'b0;
    for (int i = 4; i < 16; i++)
      send(32'(i), 12'(i % 4), 64'h100 + 64'(i), (i == 15), acc_tmp);
    nz_valid = 1'b0; nz_last = 1'b0;
    wait_eof(2, "t2_eof");
    chk("t2_push_count", 64'(q_v1.size()), 64'd16);
    if (q_v1.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        chk("t2_v0", q_v0[i], 64'h100 + 64'(i));
        chk("t2_v1", q_v1[i], xv[i % 4]);
      end
    end
    chk("t2_nz_count_at_eof", 64'(eof_nzc), 64'd16);

    // Row modulo
    clear_q();
    send(32'd1030, 12'd1, 64'h200, 1'b1, acc_tmp);
    nz_valid = 1'b0; nz_last = 1'b0;
    wait_eof(3, "t3_eof");
    chk("t3_push_count", 64'(q_row.size()), 64'd1);
    if (q_row.size() == 1) begin
      chk("t3_mac_row", 64'(q_row[0]), 64'd6);
      chk("t3_v1", q_v1[0], D20);
    end

    // Decreasing row detection
    clear_q();
    send(32'd5, 12'd0, 64'h5, 1'b0, acc_tmp);
    chk("t4_err_after_1", 64'(row_err), 64'(1'b0));
    send(32'd7, 12'd1, 64'h7, 1'b0, acc_tmp);
    chk("t4_err_after_2", 64'(row_err), 64'(1'b0));
    send(32'd3, 12'd2, 64'h3, 1'b1, acc_tmp);
    chk("t4_err_after_3", 64'(row_err), 64'(1'b1));
    nz_valid = 1'b0; nz_last = 1'b0;
    wait_eof(4, "t4_eof");
    chk("t4_push_count", 64'(q_row.size()), 64'd3);
    if (q_row.size() == 3) chk("t4_row_2", 64'(q_row[2]), 64'd3);
    chk("t4_err_sticky", 64'(row_err), 64'(1'b1));

    // vec_wr throttling mid-stream, x[2] rewritten to 8.0
    clear_q();
    exp_v1.delete();
    for (int k = 0; k < 10; k++) begin
      vec_wr = (k >= 3 && k < 6);
      vec_addr = 12'd2; vec_data = D80;
      nz_valid = 1'b1; nz_row = 32'(k); nz_col = 12'd2; nz_val = 64'(k); nz_last = (k == 9);
      @(negedge clk);
      chk("t5_ready", 64'(nz_ready), 64'(!vec_wr));
      if (nz_ready) exp_v1.push_back((k < 3) ? D30 : D80);
      tick();
    end
    vec_wr = 1'b0; nz_valid = 1'b0; nz_last = 1'b0;
    wait_eof(5, "t5_eof");
    chk("t5_push_count", 64'(q_v1.size()), 64'd7);
    if (q_v1.size() == 7 && exp_v1.size() == 7) begin
      for (int i = 0; i < 7; i++) chk("t5_v1", q_v1[i], exp_v1[i]);
    end

    // Reset with entries queued
    clear_q();
    mac_stall = 1'b1;
    for (int i = 0; i < 3; i++) send(32'(i), 12'd0, 64'(i), 1'b0, acc_tmp);
    nz_valid = 1'b0;
    tick(); tick();
    chk("t6_busy_before", 64'(busy), 64'(1'b1));
    rst = 1'b0;
    #1;
    chk("t6_rst_mac_wr",  64'(mac_wr),  64'(1'b0));
    chk("t6_rst_mac_eof", 64'(mac_eof), 64'(1'b0));
    chk("t6_rst_busy",    64'(busy),    64'(1'b0));
    tick();
    rst = 1'b1;
    mac_stall = 1'b0;
    for (int k = 0; k < 100; k++) tick();
    chk("t6_no_push", 64'(q_v1.size()), 64'd0);
    chk("t6_no_eof", 64'(eof_cnt), 64'd5);
    chk("t6_nz_count", 64'(nz_count), 64'd0);
    chk("t6_row_err_cleared", 64'(row_err), 64'(1'b0));
    send(32'd0, 12'd0, 64'h300, 1'b1, acc_tmp);
    nz_valid = 1'b0; nz_last = 1'b0;
    wait_eof(6, "t6_eof");
    chk("t6_new_push_count", 64'(q_v1.size()), 64'd1);
    if (q_v1.size() == 1) chk("t6_ram_kept", q_v1[0], D10);
    chk("t6_nz_count_at_eof", 64'(eof_nzc), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
